// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM sequencing controller.
// Holds the FSM state encoding, SRAM bus widths, default parameters and the address-to-word helper.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W         = 17;
  localparam int SRAM_DATA_W         = 64;
  localparam int DEFAULT_BASE_ADDR   = 1024;
  localparam int DEFAULT_WAIT_CYCLES = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Out-of-range addresses wrap silently by truncation to the SRAM word width.
  function automatic logic [SRAM_ADDR_W-1:0] word_index(input logic [31:0] byte_addr,
                                                        input logic [31:0] base);
    logic [31:0] offset;
    offset = byte_addr - base;
    return SRAM_ADDR_W'(offset >> 2);
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one SRAM access.
// Clear wins over enable; tc is high while the count sits at WAIT_CYCLES-1.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 5,
  localparam int CNT_W = $clog2(WAIT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == LAST);

endmodule

// File: rtl/sram_controller.sv
// Turns single-word core requests into fixed-length wait-stated accesses on a 64-bit SRAM,
// returning the selected 32-bit word and the raw 64-bit pair.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic [SRAM_DATA_W-1:0] read_data_64,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ
);

  localparam logic [31:0] BASE_ADDR_32 = 32'(BASE_ADDR);

  state_e                 state_q, state_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [SRAM_DATA_W-1:0] rdata64_q, rdata64_d;
  logic                   is_write_q, is_write_d;
  logic                   req;
  logic                   cnt_clr;
  logic                   cnt_en;
  logic                   cnt_tc;
  logic                   drive_dq;

  assign req = wr_en | rd_en;

  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rdata64_q  <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rdata64_q  <= rdata64_d;
      is_write_q <= is_write_d;
    end
  end

  // DONE always falls back to IDLE, so a request still held there is treated as consumed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (req) state_d = ST_ACCESS;
      ST_ACCESS: if (cnt_tc) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Write wins when both requests arrive together; read data is captured on the last ACCESS edge.
  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    rdata_d    = rdata_q;
    rdata64_d  = rdata64_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    if (state_q == ST_IDLE && req) begin
      addr_d     = word_index(address, BASE_ADDR_32);
      wdata_d    = write_data;
      is_write_d = wr_en;
      cnt_clr    = 1'b1;
    end
    if (state_q == ST_ACCESS) begin
      cnt_en = 1'b1;
      if (cnt_tc && !is_write_q) begin
        rdata64_d = SRAM_DQ;
        rdata_d   = addr_q[0] ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
      end
    end
  end

  // Handshake: a request is held until ready is seen high; ready drops combinationally in IDLE
  // when a request appears, stays low through ACCESS and returns high for the single DONE cycle.
  always_comb begin
    ready    = 1'b0;
    drive_dq = 1'b0;
    unique case (state_q)
      ST_IDLE:   ready = !req;
      ST_ACCESS: drive_dq = is_write_q;
      ST_DONE:   ready = 1'b1;
      default:   ready = 1'b1;
    endcase
  end

  // The write strobe and the DQ driver share one enable, so DQ is never released with WE_N low.
  assign SRAM_WE_N    = !drive_dq;
  assign SRAM_DQ      = drive_dq ? {32'b0, wdata_q} : 'z;
  assign SRAM_ADDR    = addr_q;
  assign read_data    = rdata_q;
  assign read_data_64 = rdata64_q;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: table-driven requests against a small SRAM model,
// a read-data scoreboard, and hand-written reset sequences.
`timescale 1ns/1ps
module tb_sram_controller;

  localparam int WAIT = 5;
  localparam int LAT  = WAIT + 1;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [63:0] read_data_64;
  logic        ready;
  logic [16:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  wire  [63:0] SRAM_DQ;

  int n_cmp = 0;
  int n_err = 0;

  logic [95:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [16:0] exp_addr;
    logic [31:0] exp_rd;
    logic [63:0] exp_rd64;
  } vec_t;

  vec_t vecs[12];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(WAIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .read_data_64 (read_data_64),
    .ready        (ready),
    .SRAM_ADDR    (SRAM_ADDR),
    .SRAM_WE_N    (SRAM_WE_N),
    .SRAM_DQ      (SRAM_DQ)
  );

  // ---------------- SRAM model: 32 words, pair read {odd, even}, word write from DQ[31:0] ----------------
  logic [31:0] mem [32];
  logic        model_oe;
  logic        probe_en = 1'b0;

  assign model_oe = !ready && SRAM_WE_N;
  assign SRAM_DQ  = model_oe ? {mem[SRAM_ADDR[4:0] | 5'd1], mem[SRAM_ADDR[4:0] & 5'h1E]} : 'z;
  assign SRAM_DQ  = probe_en ? 64'h0 : 'z;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
    end else if (!SRAM_WE_N) begin
      mem[SRAM_ADDR[4:0]] <= SRAM_DQ[31:0];
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // With only a zero-driving probe on the bus, any DUT drive shows up as a non-zero or X value.
  task automatic check_released(input string name);
    probe_en = 1'b1;
    #1;
    check(name, {32'h0, SRAM_DQ}, 96'h0);
    probe_en = 1'b0;
  endtask

  // ---------------- driver: one request, held until ready is seen high ----------------
  task automatic run_req(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [16:0] exp_addr,
                         input logic [31:0] exp_rd, input logic [63:0] exp_rd64,
                         input string tag);
    int          lat;
    int          we_low;
    logic [63:0] dq_first;
    logic        done;
    logic [95:0] exp;
    @(posedge clk);
    #1;
    wr_en      = wr;
    rd_en      = rd;
    address    = addr;
    write_data = data;
    exp_q.push_back({exp_rd64, exp_rd});
    lat      = 0;
    we_low   = 0;
    dq_first = '0;
    done     = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (ready) begin
        done = 1'b1;
      end else begin
        lat++;
        if (!SRAM_WE_N) we_low++;
        if (c == 1) dq_first = SRAM_DQ;
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    check({tag, " latency"}, 96'(lat), 96'(LAT));
    check({tag, " we_n low cycles"}, 96'(we_low), wr ? 96'(WAIT) : 96'd0);
    check({tag, " sram_addr"}, 96'(SRAM_ADDR), 96'(exp_addr));
    if (wr) check({tag, " write dq"}, 96'(dq_first), {32'h0, 32'h0, data});
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s scoreboard: got empty queue, expected one entry", tag);
    end else begin
      exp = exp_q.pop_front();
      check({tag, " read data"}, {read_data_64, read_data}, exp);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst        = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    address    = '0;
    write_data = '0;

    // fields: wr, rd, addr, data, exp_addr, exp_rd, exp_rd64
    vecs[0]  = '{1'b0, 1'b1, 32'd1032,   32'h0,        17'd2,       32'd2,        {32'd3, 32'd2}};
    vecs[1]  = '{1'b0, 1'b1, 32'd1036,   32'h0,        17'd3,       32'd3,        {32'd3, 32'd2}};
    vecs[2]  = '{1'b1, 1'b0, 32'd1040,   32'hDEADBEEF, 17'd4,       32'd3,        {32'd3, 32'd2}};
    vecs[3]  = '{1'b0, 1'b1, 32'd1040,   32'h0,        17'd4,       32'hDEADBEEF, {32'd5, 32'hDEADBEEF}};
    vecs[4]  = '{1'b0, 1'b1, 32'd1044,   32'h0,        17'd5,       32'd5,        {32'd5, 32'hDEADBEEF}};
    vecs[5]  = '{1'b1, 1'b1, 32'd1048,   32'h12345678, 17'd6,       32'd5,        {32'd5, 32'hDEADBEEF}};
    vecs[6]  = '{1'b0, 1'b1, 32'd1052,   32'h0,        17'd7,       32'd7,        {32'd7, 32'h12345678}};
    vecs[7]  = '{1'b0, 1'b1, 32'd1024,   32'h0,        17'd0,       32'd0,        {32'd1, 32'd0}};
    vecs[8]  = '{1'b0, 1'b1, 32'd1020,   32'h0,        17'h1FFFF,   32'd31,       {32'd31, 32'd30}};
    vecs[9]  = '{1'b0, 1'b1, 32'd525348, 32'h0,        17'd9,       32'd9,        {32'd9, 32'd8}};
    vecs[10] = '{1'b1, 1'b0, 32'd1028,   32'hCAFEF00D, 17'd1,       32'd9,        {32'd9, 32'd8}};
    vecs[11] = '{1'b0, 1'b1, 32'd1024,   32'h0,        17'd0,       32'd0,        {32'hCAFEF00D, 32'd0}};

    // reset held for two cycles
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset ready", 96'(ready), 96'd1);
    check("reset we_n", 96'(SRAM_WE_N), 96'd1);
    check("reset sram_addr", 96'(SRAM_ADDR), 96'd0);
    check("reset read data", {read_data_64, read_data}, 96'h0);
    check_released("reset dq released");

    for (int v = 0; v < 12; v++) begin
      run_req(vecs[v].wr, vecs[v].rd, vecs[v].addr, vecs[v].data, vecs[v].exp_addr,
              vecs[v].exp_rd, vecs[v].exp_rd64, $sformatf("vec%0d", v));
    end

    // idle after the last access: bus released, strobe high, ready high
    @(negedge clk);
    check("idle ready", 96'(ready), 96'd1);
    check("idle we_n", 96'(SRAM_WE_N), 96'd1);
    check_released("idle dq released");

    // reset asserted during ACCESS cycle 2 of a write
    @(posedge clk);
    #1;
    wr_en      = 1'b1;
    address    = 32'd1056;
    write_data = 32'hA5A55A5A;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    check("midreset we_n before abort", 96'(SRAM_WE_N), 96'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midreset we_n after abort", 96'(SRAM_WE_N), 96'd1);
    check("midreset ready", 96'(ready), 96'd1);
    check("midreset read data cleared", {read_data_64, read_data}, 96'h0);
    check_released("midreset dq released");

    run_req(1'b0, 1'b1, 32'd1032, 32'h0, 17'd2, 32'd2, {32'd3, 32'd2}, "post-reset read");

    check("scoreboard drained", 96'(exp_q.size()), 96'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected sequence to finish");
    $fatal(1);
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Sequencing controller between the ARM core's memory stage and the external 64-bit-wide SRAM. It converts single-word read/write requests into a fixed-length, wait-stated SRAM access and drives the SRAM address, write-enable and bidirectional data bus. It returns the selected 32-bit word, plus the full 64-bit pair for a later cache fill. While an access is in flight it deasserts `ready` to freeze the pipeline.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `WAIT_CYCLES`, 5: SRAM access cycles per request, minimum 2 (covers 30 ns bus turnaround at 20 ns clock).

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  write request, held until `ready` seen high.
- `rd_en`  in  1  read request, held until `ready` seen high.
- `address`  in  32  byte address of request.
- `write_data`  in  32  write word.
- `read_data`  out  32  selected read word.
- `read_data_64`  out  64  raw SRAM pair {odd word, even word}.
- `ready`  out  1  1 = idle or access complete; 0 = stall.
- `SRAM_ADDR`  out  17  SRAM word address.
- `SRAM_WE_N`  out  1  active-low SRAM write strobe.
- `SRAM_DQ`  inout  64  SRAM data bus.

## Operation
- Word index = `(address - BASE_ADDR) >> 2`, truncated to 17 bits. Out-of-range addresses wrap by truncation, with no error.
- States: IDLE, ACCESS, DONE.
- IDLE: on `wr_en` or `rd_en`, capture the index into `SRAM_ADDR`, latch `write_data` and the op type, clear the counter, and go to ACCESS. If both requests are high, the write wins.
- ACCESS: the counter increments each cycle. At count `WAIT_CYCLES-1`, go to DONE.
- ACCESS write: `SRAM_WE_N`=0 throughout ACCESS. `SRAM_DQ` driven with {32'b0, latched data}.
- ACCESS read: `SRAM_WE_N`=1 and `SRAM_DQ` high-Z. On the final ACCESS edge, register `SRAM_DQ` into `read_data_64`. `read_data` = upper half if index bit 0 is 1, else lower half.
- DONE: `ready`=1 and `SRAM_WE_N`=1. Unconditionally return to IDLE. A request still high in DONE is not restarted; it is treated as consumed.
- `ready` = 1 in DONE, or in IDLE with no request. It is 0 in IDLE with a request (combinational) and throughout ACCESS.
- `read_data`/`read_data_64` hold their last read value across writes and idle periods.

## Timing
- Request seen in IDLE at cycle 0.
- ACCESS runs cycles 1..WAIT_CYCLES. DONE is cycle WAIT_CYCLES+1.
- `ready` is low for exactly WAIT_CYCLES+1 cycles per request. Back-to-back requests can re-enter ACCESS from the IDLE cycle that follows DONE.
- The read result is valid from the DONE cycle onward.
- Reset (synchronous, `rst`=0) values:
  - state IDLE, counter 0;
  - `SRAM_ADDR` 0, `SRAM_WE_N` 1, `SRAM_DQ` high-Z;
  - `read_data` 0, `read_data_64` 0;
  - `ready` 1 (no request).
- Reset mid-ACCESS aborts at that edge. `SRAM_WE_N` is high from the next cycle, and an interrupted write may have reached SRAM.
- Bus contention is forbidden: `SRAM_DQ` is driven only in ACCESS of a write, and `SRAM_WE_N` is high whenever DQ is released.

## Structure
- Package `sram_ctrl_pkg`:
  - state enum (IDLE/ACCESS/DONE);
  - `SRAM_ADDR_W`=17 and `SRAM_DATA_W`=64;
  - default `BASE_ADDR` and `WAIT_CYCLES`.
- Sub-module `sram_wait_counter`: clear/enable counter with a terminal-count output, width $clog2(WAIT_CYCLES). The FSM and bus drivers stay in the top module.

## Test plan
The bench's SRAM model is reset with the inverted controller reset. After model reset, word i holds value i.
- Reset: hold `rst`=0 for 2 cycles, then release. Expect `ready`=1, `SRAM_WE_N`=1, `SRAM_DQ`=Z, `read_data`=0.
- Even-word read: `rd_en` with `address`=1032 (index 2). Expect `ready` low for 6 cycles, `SRAM_ADDR`=2, then `read_data`=2 and `read_data_64`={3,2} in DONE.
- Odd-word read: `address`=1036 (index 3). Expect `read_data`=3 and `SRAM_ADDR`=3.
- Write then read: write 0xDEADBEEF to 1040 (index 4).
  - During ACCESS, expect `SRAM_WE_N`=0 and DQ[31:0]=0xDEADBEEF.
  - A following read of 1040 returns 0xDEADBEEF.
  - A read of 1044 returns 5, with `read_data_64`={5,0xDEADBEEF}.
- Simultaneous `rd_en`=`wr_en`=1 at 1048 with data 0x12345678: expect a write (`SRAM_WE_N`=0) and `read_data` unchanged.
- Reset mid-write:
  - Assert `rst`=0 at ACCESS cycle 2. Next cycle expect IDLE, `SRAM_WE_N`=1 and DQ=Z.
  - A new read completes normally with latency 6.
